pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised, pipelined add/subtract unit; successor to the 1-bit gate-level full adder.
//  WIDTH-bit operands split into STAGES equal chunks; one chunk resolved per stage, carry
//  registered between stages. Valid/ready on both sides; accepts one op per cycle.
//  Sits between operand sources and datapath consumers needing >1-chunk adds at high fmax.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline depth = latency in cycles; chunk width CW = WIDTH/STAGES (>=1)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands/mode valid
//  in_ready   out  1      unit accepts operands this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in (add) / borrow-in (sub)
//  in_sub     in   1      0: A+B+cin   1: A-B-cin
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer takes result this cycle
//  out_sum    out  WIDTH  result modulo 2^WIDTH
//  out_cout   out  1      add: carry-out; sub: borrow-out (1 = A < B+cin unsigned)
//  out_ovf    out  1      signed two's-complement overflow
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0, out_valid=0, out_sum=0,
//    out_cout=0, out_ovf=0; partial data discarded. Reset mid-operation drops in-flight ops.
//  - Transfer on each side when valid && ready, same cycle.
//  - Global advance: adv = out_ready || !out_valid; in_ready = adv (combinational from
//    out_ready; no combinational path from in_valid to in_ready). When adv=0 every stage
//    register (data + valid) holds; out_sum/out_cout/out_ovf stable while out_valid && !out_ready.
//  - Bubbles are not collapsed; stage valid bits shift with data on adv.
//  - Latency exactly STAGES cycles accept->out_valid with out_ready held 1; throughput 1/cycle.
//  - Arithmetic: B' = in_sub ? ~in_b : in_b; c0 = in_sub ? ~in_cin : in_cin.
//    Stage k (0..STAGES-1) computes chunk k: {c_k+1, s_k} = A_k + B'_k + c_k, CW+1 bits,
//    c_k taken from stage k-1 register. Unconsumed upper A/B' chunks delayed alongside
//    (triangular skew); completed lower sum chunks carried forward (de-skew).
//  - out_cout = c_STAGES ^ sub (borrow is inverted carry). out_ovf = carry into MSB ^
//    carry out of MSB, computed in last stage; independent of sub.
//  - Mode, cin captured at accept and travel with the op; mixing add/sub back-to-back legal.
//  - STAGES=1: single registered adder, latency 1. No internal error states; no FSM beyond
//    per-stage valid bits.
// STRUCTURE
//  - Package adder_pkg: localparam CW function/check, SUB/ADD mode encoding constants.
//  - Sub-module adder_chunk (combinational, CW-bit ripple of full-adder cells; exports
//    carry into and out of chunk MSB for ovf); instantiated STAGES times via generate.
//  - Top holds stage valid/data registers, skew/de-skew registers, handshake logic.
//  - Elaboration-time error if WIDTH % STAGES != 0.
// TESTING (WIDTH=16, STAGES=4)
//  1 Reset: assert rst mid-stream -> out_valid=0, outputs 0 same cycle; in_ready=1 after.
//  2 Add 0xFFFF+0x0001 cin=0 -> after 4 cycles sum=0x0000 cout=1 ovf=0.
//  3 Sub 0x8000-0x0001 cin=0 -> sum=0x7FFF cout=0 ovf=1; sub 0x0003-0x0005 cin=1 -> 0xFFFD cout=1.
//  4 Stream 8 back-to-back mixed add/sub ops, out_ready=1 -> 8 results on consecutive cycles, in order.
//  5 Backpressure: out_ready=0 for 3 cycles with full pipe -> in_ready=0, out_sum stable, no loss/dup.
//  6 Random 10k ops vs reference model a+b+cin / a-b-cin incl. carry chains across all chunks.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   MODE_ADD / MODE_SUB : encoding of the in_sub mode bit
//   chunk_width()       : bits resolved per pipeline stage
//   chunk_ok()          : parameter legality (WIDTH splits evenly into STAGES chunks)
package adder_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit chunk_ok(input int width, input int stages);
        return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// One pipeline chunk: CW-bit ripple of full-adder cells, purely combinational.
//   a, b  : chunk operands (b already inverted for subtract)
//   ci    : carry into the chunk LSB
//   s     : chunk sum
//   co    : carry out of the chunk MSB
//   cmsb  : carry into the chunk MSB (used for signed overflow on the top chunk)
module adder_chunk
    import adder_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          cmsb
);

    logic [CW:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co   = c[CW];
    assign cmsb = c[CW-1];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit. WIDTH-bit operands are resolved CW = WIDTH/STAGES bits
// per stage, with the chunk carry registered between stages. Latency STAGES cycles,
// one op accepted per cycle, whole pipe stalls together under backpressure.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operand handshake (in_ready depends only on output side)
//   in_a, in_b            : operands
//   in_cin                : carry-in (add) / borrow-in (sub)
//   in_sub                : 0 = A+B+cin, 1 = A-B-cin
//   out_valid / out_ready : result handshake
//   out_sum               : result modulo 2^WIDTH
//   out_cout              : carry-out (add) / borrow-out (sub)
//   out_ovf               : signed two's-complement overflow
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!chunk_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of STAGES (%0d)",
               WIDTH, STAGES);
    end

    logic adv;
    logic [STAGES:0] vld_pipe;

    // Per stage, x holds completed sum chunks below/at the stage and still-pending A chunks
    // above it; y holds only the pending B' chunks (resolved chunks are zeroed so their
    // flops are constant and drop out). Together they form the skew/de-skew triangle.
    logic [STAGES-1:0][WIDTH-1:0] x_in, y_in, x_nxt, y_nxt, x_q, y_q;
    logic [STAGES-1:0]            c_in, sub_in, c_out, c_msb, c_q, sub_q;
    logic                         ovf_q;

    // Whole pipe advances together; bubbles travel with the data.
    assign adv         = out_ready || !out_valid;
    assign in_ready    = adv;
    assign vld_pipe[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam logic [WIDTH-1:0] MASK = WIDTH'({CW{1'b1}}) << (k * CW);
        logic [CW-1:0] s;

        if (k == 0) begin : g_first
            // Subtract as A + ~B + ~borrow_in.
            assign x_in[0]   = in_a;
            assign y_in[0]   = (in_sub == MODE_SUB) ? ~in_b : in_b;
            assign c_in[0]   = (in_sub == MODE_SUB) ? ~in_cin : in_cin;
            assign sub_in[0] = in_sub;
        end else begin : g_next
            assign x_in[k]   = x_q[k-1];
            assign y_in[k]   = y_q[k-1];
            assign c_in[k]   = c_q[k-1];
            assign sub_in[k] = sub_q[k-1];
        end

        adder_chunk #(.CW(CW)) u_chunk (
            .a    (x_in[k][k*CW +: CW]),
            .b    (y_in[k][k*CW +: CW]),
            .ci   (c_in[k]),
            .s    (s),
            .co   (c_out[k]),
            .cmsb (c_msb[k])
        );

        assign x_nxt[k] = (x_in[k] & ~MASK) | (WIDTH'(s) << (k * CW));
        assign y_nxt[k] = y_in[k] & ~MASK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[STAGES:1] <= '0;
            x_q                <= '0;
            y_q                <= '0;
            c_q                <= '0;
            sub_q              <= '0;
            ovf_q              <= 1'b0;
        end else if (adv) begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            x_q                <= x_nxt;
            y_q                <= y_nxt;
            c_q                <= c_out;
            sub_q              <= sub_in;
            // Signed overflow: carry into MSB differs from carry out of MSB.
            ovf_q              <= c_msb[STAGES-1] ^ c_out[STAGES-1];
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_sum   = x_q[STAGES-1];
    // Borrow is the inverted carry in subtract mode.
    assign out_cout  = c_q[STAGES-1] ^ sub_q[STAGES-1];
    assign out_ovf   = ovf_q;

    // Last-stage B' chunks and lower-stage MSB carries have no consumer.
    logic unused_ok;
    assign unused_ok = ^{y_q[STAGES-1], c_msb};

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_cin;
    logic        in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    int checks = 0;
    int errors = 0;

    pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    // {ovf, cout, sum} from plain integer arithmetic.
    function automatic logic [17:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic cin, input logic sub);
        logic [16:0] r;
        int sa, sb, t;
        sa = $signed(a);
        sb = $signed(b);
        if (!sub) begin
            r = {1'b0, a} + {1'b0, b} + {16'd0, cin};
            t = sa + sb + int'(cin);
        end else begin
            r = {1'b0, a} - {1'b0, b} - {16'd0, cin};
            t = sa - sb - int'(cin);
        end
        return {(t > 32767) || (t < -32768), r[16], r[15:0]};
    endfunction

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub, input logic ordy);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        in_sub    = sub;
        out_ready = ordy;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(0, 16'h0, 16'h0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_ovf, out_cout, out_sum} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {out_valid, out_ovf, out_cout, out_sum});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 16'h0011, 16'h0022, 0, 0, 1);
        end
        @(negedge clk);
        drive(0, 16'h0, 16'h0, 0, 0, 1);
        checks++;
        if ({out_valid, out_ovf, out_cout, out_sum} !== {1'b1, 18'h00033}) begin
            errors++;
            $display("FAIL prereset_result: got %h expected %h",
                     {out_valid, out_ovf, out_cout, out_sum}, {1'b1, 18'h00033});
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_ovf, out_cout, out_sum} !== 19'd0) begin
            errors++;
            $display("FAIL midreset_outputs: got %h expected 0", {out_valid, out_ovf, out_cout, out_sum});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_in_ready: got %b expected 1", in_ready);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_dropped: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_add_carry;
        @(negedge clk);
        drive(1, 16'hFFFF, 16'h0001, 0, 0, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            drive(0, 16'h0, 16'h0, 0, 0, 1);
            if (i < 4) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL add_latency_early: cycle %0d got out_valid=%b expected 0", i, out_valid);
                end
            end else begin
                checks++;
                if ({out_valid, out_ovf, out_cout, out_sum} !== {1'b1, 1'b0, 1'b1, 16'h0000}) begin
                    errors++;
                    $display("FAIL add_carry_chain: got %h expected %h",
                             {out_valid, out_ovf, out_cout, out_sum}, {1'b1, 1'b0, 1'b1, 16'h0000});
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_sub;
        @(negedge clk);
        drive(1, 16'h8000, 16'h0001, 0, 1, 1);
        @(negedge clk);
        drive(1, 16'h0003, 16'h0005, 1, 1, 1);
        @(negedge clk);
        drive(0, 16'h0, 16'h0, 0, 0, 1);
        repeat (2) @(negedge clk);
        checks++;
        if ({out_valid, out_ovf, out_cout, out_sum} !== {1'b1, 1'b1, 1'b0, 16'h7FFF}) begin
            errors++;
            $display("FAIL sub_ovf: got %h expected %h",
                     {out_valid, out_ovf, out_cout, out_sum}, {1'b1, 1'b1, 1'b0, 16'h7FFF});
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_ovf, out_cout, out_sum} !== {1'b1, 1'b0, 1'b1, 16'hFFFD}) begin
            errors++;
            $display("FAIL sub_borrow: got %h expected %h",
                     {out_valid, out_ovf, out_cout, out_sum}, {1'b1, 1'b0, 1'b1, 16'hFFFD});
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        // {sub, cin, a, b} and hand-computed {ovf, cout, sum}
        logic [33:0] ops [8];
        logic [17:0] exp [8];
        ops[0] = {1'b0, 1'b0, 16'h1234, 16'h1111}; exp[0] = {1'b0, 1'b0, 16'h2345};
        ops[1] = {1'b1, 1'b0, 16'h1000, 16'h0001}; exp[1] = {1'b0, 1'b0, 16'h0FFF};
        ops[2] = {1'b0, 1'b0, 16'h7FFF, 16'h0001}; exp[2] = {1'b1, 1'b0, 16'h8000};
        ops[3] = {1'b1, 1'b0, 16'h0000, 16'h0001}; exp[3] = {1'b0, 1'b1, 16'hFFFF};
        ops[4] = {1'b0, 1'b1, 16'h0F0F, 16'h00F1}; exp[4] = {1'b0, 1'b0, 16'h1001};
        ops[5] = {1'b1, 1'b0, 16'h8000, 16'h7FFF}; exp[5] = {1'b1, 1'b0, 16'h0001};
        ops[6] = {1'b0, 1'b0, 16'h8000, 16'h8000}; exp[6] = {1'b1, 1'b1, 16'h0000};
        ops[7] = {1'b1, 1'b1, 16'hFFFF, 16'hFFFF}; exp[7] = {1'b0, 1'b1, 16'hFFFF};
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i >= 4) begin
                checks++;
                if ({out_valid, out_ovf, out_cout, out_sum} !== {1'b1, exp[i-4]}) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got %h expected %h", i - 4,
                             {out_valid, out_ovf, out_cout, out_sum}, {1'b1, exp[i-4]});
                end
            end else begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_fill[%0d]: got out_valid=%b expected 0", i, out_valid);
                end
            end
            if (i < 8) drive(1, ops[i][31:16], ops[i][15:0], ops[i][32], ops[i][33], 1);
            else       drive(0, 16'h0, 16'h0, 0, 0, 1);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_backpressure;
        logic [33:0] ops [6];
        int nin = 0;
        int nout = 0;
        logic ordy;
        for (int i = 0; i < 6; i++)
            ops[i] = {1'(i % 2), 1'(i / 3), 16'h3000 + 16'(i) * 16'h1111, 16'h0F00 + 16'(i)};
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            ordy = !(k >= 4 && k < 7);
            if (out_valid) begin
                checks++;
                if (nout >= 6) begin
                    errors++;
                    $display("FAIL bp_extra_result: got %h expected none", out_sum);
                end else if ({out_ovf, out_cout, out_sum} !==
                             ref_model(ops[nout][31:16], ops[nout][15:0], ops[nout][32], ops[nout][33])) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got %h expected %h", nout, {out_ovf, out_cout, out_sum},
                             ref_model(ops[nout][31:16], ops[nout][15:0], ops[nout][32], ops[nout][33]));
                end
                if (ordy) nout++;
            end
            if (nin < 6) drive(1, ops[nin][31:16], ops[nin][15:0], ops[nin][32], ops[nin][33], ordy);
            else         drive(0, 16'h0, 16'h0, 0, 0, ordy);
            #1;
            if (k >= 4 && k < 7) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_in_ready[%0d]: got %b expected 0", k, in_ready);
                end
            end
            if (in_valid && in_ready) nin++;
        end
        checks++;
        if (nout !== 6 || nin !== 6) begin
            errors++;
            $display("FAIL bp_count: got in=%0d out=%0d expected 6/6", nin, nout);
        end
    endtask

    task automatic test_random;
        logic [17:0] exp_q [$];
        logic [17:0] e;
        logic [15:0] a, b;
        logic        cin, sub, v, ordy;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        while ((sent < 10000 || recv < sent) && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            ordy = ($urandom_range(0, 3) != 0);
            if (out_valid && ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected: got %h expected none", {out_ovf, out_cout, out_sum});
                end else begin
                    e = exp_q.pop_front();
                    if ({out_ovf, out_cout, out_sum} !== e) begin
                        errors++;
                        $display("FAIL rand_result[%0d]: got %h expected %h", recv,
                                 {out_ovf, out_cout, out_sum}, e);
                    end
                end
                recv++;
            end
            v   = (sent < 10000) && ($urandom_range(0, 3) != 0);
            a   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            b   = ($urandom_range(0, 3) == 0) ? 16'h0001 : 16'($urandom);
            cin = 1'($urandom);
            sub = 1'($urandom);
            drive(v, a, b, cin, sub, ordy);
            #1;
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(a, b, cin, sub));
                sent++;
            end
        end
        drive(0, 16'h0, 16'h0, 0, 0, 1);
        checks++;
        if (sent != 10000 || recv != sent) begin
            errors++;
            $display("FAIL rand_timeout: got sent=%0d recv=%0d expected 10000/10000", sent, recv);
        end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_sub();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
